// File: rtl/fir_proc_pkg.sv
// rtl/fir_proc_pkg.sv - shared constants, fsm state enum and pc helper for the FIR processor
//
// Purpose : common definitions imported by the fetch sequencer, its interface and call stack.
// Contents: ADDR_W / INSTR_W widths, fsm_state_t (IDLE/RUN/HALT/ERROR), pc_inc() wrap-around add.
package fir_proc_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    ERROR = 2'd3
  } fsm_state_t;

  // Sequential successor of a program counter; wraps 2**ADDR_W-1 -> 0 silently.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory, decode handshake and redirect bundle
//
// Purpose : groups the signals between the fetch sequencer, the async instruction memory
//           and the decode stage.
// Signals : im_addr/im_instr       memory address out, read data back (same cycle)
//           instr/instr_pc         registered instruction and its address
//           instr_valid/ready      decode handshake, fire = valid & ready
//           jump_*/call_*/ret_en   redirect requests, sampled on fire only
//           halt_en                stop after the firing instruction
// Modports: master = fetch sequencer side, slave = memory/decode side.
interface fetch_sequencer_if
  import fir_proc_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int IW = INSTR_W
);

  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_instr;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump_en;
  logic [AW-1:0] jump_target;
  logic          call_en;
  logic [AW-1:0] call_target;
  logic          ret_en;
  logic          halt_en;

  modport master (
    output im_addr,
    input  im_instr,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  jump_en,
    input  jump_target,
    input  call_en,
    input  call_target,
    input  ret_en,
    input  halt_en
  );

  modport slave (
    input  im_addr,
    output im_instr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output jump_en,
    output jump_target,
    output call_en,
    output call_target,
    output ret_en,
    output halt_en
  );

endinterface

// File: rtl/fetch_sequencer_call_stack.sv
// rtl/fetch_sequencer_call_stack.sv - LIFO of return addresses for call/ret
//
// Purpose : DEPTH-entry return-address stack. The caller never issues push and pop in the
//           same cycle; push when full and pop when empty are dropped here as a safety net.
// Ports   : clk, rst_n (sync active-low), clear (empty the stack), push/push_data, pop,
//           top (current top entry, undefined when empty), full, empty.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      cnt;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  // cnt holds DEPTH+1 distinct values; its low bits are the next free slot.
  assign wr_idx  = cnt[PW-1:0];
  assign top_idx = wr_idx - PW'(1);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign top     = mem[top_idx];

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear && !push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + (PW+1)'(1);
    end else if (do_pop) begin
      cnt <= cnt - (PW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and fetch controller for the FIR instruction memory
//
// Purpose : drives the async instruction memory address, registers the returned word and
//           offers it to decode on a valid/ready handshake. Handles jump, call, return,
//           halt and stack error trapping.
// Ports   : clk, rst_n (sync active-low), start (honoured in IDLE/HALT),
//           bus (fetch_sequencer_if.master: memory, decode handshake, redirects),
//           busy (state is RUN), err_overflow / err_underflow (sticky until reset).
module fetch_sequencer
  import fir_proc_pkg::*;
#(
  parameter int                         STACK_DEPTH = 4,
  parameter logic [fir_proc_pkg::ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  fetch_sequencer_if.master   bus,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_underflow
);

  fsm_state_t         state_q;
  fsm_state_t         state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               err_ovf_q;
  logic               err_unf_q;

  logic [ADDR_W-1:0]  pc_next;
  logic               fire;
  logic               load;
  logic               stk_clear;
  logic               stk_push;
  logic               stk_pop;
  logic               set_ovf;
  logic               set_unf;
  logic [ADDR_W-1:0]  stk_top;
  logic               stk_full;
  logic               stk_empty;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (stk_clear),
    .push      (stk_push),
    .push_data (pc_inc(instr_pc_q)),
    .pop       (stk_pop),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // instr_valid comes only from the state register, so ready never reaches it combinationally.
  assign fire = (state_q == RUN) && bus.instr_ready;

  always_comb begin
    state_d   = state_q;
    pc_next   = instr_pc_q;
    load      = 1'b0;
    stk_clear = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;

    unique case (state_q)
      IDLE, HALT: begin
        pc_next = RESET_PC;
        if (start) begin
          load      = 1'b1;
          stk_clear = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        // Without fire pc_next stays at instr_pc: the memory re-reads the held word.
        if (fire) begin
          if (bus.halt_en) begin
            state_d = HALT;
          end else if (bus.jump_en) begin
            pc_next = bus.jump_target;
            load    = 1'b1;
          end else if (bus.call_en) begin
            if (stk_full) begin
              set_ovf = 1'b1;
              state_d = ERROR;
            end else begin
              stk_push = 1'b1;
              pc_next  = bus.call_target;
              load     = 1'b1;
            end
          end else if (bus.ret_en) begin
            if (stk_empty) begin
              set_unf = 1'b1;
              state_d = ERROR;
            end else begin
              stk_pop = 1'b1;
              pc_next = stk_top;
              load    = 1'b1;
            end
          end else begin
            pc_next = pc_inc(instr_pc_q);
            load    = 1'b1;
          end
        end
      end

      ERROR: begin
        // Trapped until reset; start is deliberately ignored.
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        instr_q    <= bus.im_instr;
        instr_pc_q <= pc_next;
      end
      if (set_ovf) begin
        err_ovf_q <= 1'b1;
      end
      if (set_unf) begin
        err_unf_q <= 1'b1;
      end
    end
  end

  assign bus.im_addr     = pc_next;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = (state_q == RUN);
  assign busy            = (state_q == RUN);
  assign err_overflow    = err_ovf_q;
  assign err_underflow   = err_unf_q;

endmodule
